// File: rtl/decoder_capture_ctrl_if.sv
// Readout stream from the capture controller to the top-level readout mux.
interface decoder_capture_ctrl_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, rd_valid, input rd_ready);
  modport slave  (input rd_data, rd_valid, output rd_ready);
endinterface

// File: rtl/decoder_capture_ctrl.sv
// Arms a byte-stream decoder, captures bytes after a masked trigger, streams them out.
// Optional idle timeout in CAPTURE is compiled in with `define CAPTURE_TIMEOUT_EN.
module decoder_capture_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [7:0]            trig_val,
  input  logic [7:0]            trig_mask,
  input  logic [3:0]            cap_len,
  input  logic [7:0]            dec_data,
  input  logic                  dec_valid,
  output logic                  dec_detect_only,
  decoder_capture_ctrl_if.master rd,
  output logic [1:0]            state,
  output logic [4:0]            count,
  output logic                  timed_out
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

  state_t                st;
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [4:0]            len, len_sel;
  logic                  dec_valid_q, new_byte, trig_hit, wr_en, tmo_hit;

  assign new_byte = dec_valid & ~dec_valid_q;
  assign trig_hit = ((dec_data ^ trig_val) & trig_mask) == 8'h00;
  assign len_sel  = (cap_len == 4'd0 || 5'(cap_len) > 5'(DEPTH)) ? 5'(DEPTH) : {1'b0, cap_len};
  assign wr_en    = !abort && new_byte &&
                    ((st == S_ARMED && trig_hit) || st == S_CAPTURE);
  assign state    = st;

  // Capture storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dec_data;
  end

`ifdef CAPTURE_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign tmo_hit = (st == S_CAPTURE) && !new_byte && (idle_cnt + 16'd1 == 16'(TIMEOUT_CYCLES));

  // Counter sits at zero outside CAPTURE, so entry to CAPTURE starts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (abort || (st == S_IDLE && arm)) timed_out <= 1'b0;
      else if (tmo_hit)                   timed_out <= 1'b1;
      if (abort || st != S_CAPTURE || new_byte) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= S_IDLE;
      dec_detect_only <= 1'b1;
      rd.rd_valid     <= 1'b0;
      rd.rd_data      <= 8'h00;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      len             <= 5'(DEPTH);
      dec_valid_q     <= 1'b0;
    end else begin
      dec_valid_q <= dec_valid;
      if (abort) begin
        st              <= S_IDLE;
        dec_detect_only <= 1'b1;
        rd.rd_valid     <= 1'b0;
        count           <= '0;
        wr_ptr          <= '0;
        rd_ptr          <= '0;
      end else begin
        case (st)
          S_IDLE: if (arm) begin
            st              <= S_ARMED;
            dec_detect_only <= 1'b0;
            len             <= len_sel;
            count           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
          end
          S_ARMED: if (new_byte && trig_hit) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= 5'd1;
            if (len == 5'd1) begin
              st              <= S_READOUT;
              dec_detect_only <= 1'b1;
            end else begin
              st <= S_CAPTURE;
            end
          end
          S_CAPTURE: if (new_byte) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + 5'd1;
            if (count + 5'd1 == len) begin
              st              <= S_READOUT;
              dec_detect_only <= 1'b1;
            end
          end else if (tmo_hit) begin
            st              <= S_READOUT;
            dec_detect_only <= 1'b1;
          end
          S_READOUT: begin
            // Present one byte, pop it, then present the next a cycle later.
            if (rd.rd_valid && rd.rd_ready) begin
              rd.rd_valid <= 1'b0;
              rd_ptr      <= rd_ptr + AW'(1);
              count       <= count - 5'd1;
              if (count == 5'd1) st <= S_IDLE;
            end else if (count != 5'd0) begin
              rd.rd_valid <= 1'b1;
              rd.rd_data  <= mem[rd_ptr];
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decoder_capture_ctrl.sv
// Scoreboard bench: sessions push expected readout bytes, a monitor pops them on each handshake.
module tb_decoder_capture_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [7:0] trig_val = 8'h00, trig_mask = 8'h00, dec_data = 8'h00;
  logic [3:0] cap_len = 4'd0;
  logic       dec_valid = 1'b0;
  logic       dec_detect_only, timed_out;
  logic [1:0] state;
  logic [4:0] count;

  bit rr_rand = 1'b0, rr_force = 1'b0;
  int errs = 0, checks = 0, sb_errs = 0, sb_checks = 0;
  logic [7:0] exp_q[$];

  decoder_capture_ctrl_if rif();

  decoder_capture_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .trig_val(trig_val), .trig_mask(trig_mask), .cap_len(cap_len),
    .dec_data(dec_data), .dec_valid(dec_valid), .dec_detect_only(dec_detect_only),
    .rd(rif), .state(state), .count(count), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rif.rd_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
  end

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n && rif.rd_valid === 1'b1 && rif.rd_ready === 1'b1) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_errs++;
        $display("FAIL sb_unexpected: got %02h, expected no byte", rif.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rif.rd_data !== e) begin
          sb_errs++;
          $display("FAIL sb_data: got %02h, expected %02h", rif.rd_data, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int model_len(int cl);
    return (cl == 0 || cl > DEPTH) ? DEPTH : cl;
  endfunction

  task automatic do_arm(logic [3:0] cl, logic [7:0] tv, logic [7:0] tm);
    trig_val = tv; trig_mask = tm; cap_len = cl;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int hi, int lo);
    dec_data = b; dec_valid = 1'b1;
    tick(hi);
    dec_valid = 1'b0;
    tick(lo);
  endtask

  task automatic wait_idle(string name, int bound);
    int n = 0;
    while (state !== 2'd0 && n < bound) begin tick(); n++; end
    chk(name, state, 2'd0);
    chk({name, "_count"}, count, 5'd0);
  endtask

  // Reference: first byte matching the masked trigger starts capture, then len bytes total.
  task automatic run_session(logic [3:0] cl, logic [7:0] tv, logic [7:0] tm);
    int len = model_len(int'(cl));
    int got = 0;
    bit trig = 1'b0;
    logic [7:0] b;
    do_arm(cl, tv, tm);
    while (got < len) begin
      b = 8'($urandom);
      if (!trig && $urandom_range(0, 3) == 0) b = (tv & tm) | (b & ~tm);
      if (trig || ((b ^ tv) & tm) == 8'h00) begin
        trig = 1'b1;
        exp_q.push_back(b);
        got++;
      end
      send_byte(b, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    wait_idle("sess_idle", 400);
    chk("sess_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] b;
    tick(3);
    chk("rst_state", state, 2'd0);
    chk("rst_detect", dec_detect_only, 1'b1);
    chk("rst_rd_valid", rif.rd_valid, 1'b0);
    chk("rst_rd_data", rif.rd_data, 8'h00);
    chk("rst_count", count, 5'd0);
    chk("rst_timed_out", timed_out, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Masked trigger: 0x12 is skipped, capture 0xA5 0x33 0x44.
    rr_force = 1'b0;
    do_arm(4'd3, 8'hA0, 8'hF0);
    chk("armed_state", state, 2'd1);
    chk("armed_detect", dec_detect_only, 1'b0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_byte(8'h12, 1, 1);
    chk("nomatch_count", count, 5'd0);
    send_byte(8'hA5, 1, 1);
    chk("cap_state", state, 2'd2);
    send_byte(8'h33, 1, 1);
    send_byte(8'h44, 1, 1);
    chk("trig_readout_state", state, 2'd3);
    chk("trig_readout_detect", dec_detect_only, 1'b1);
    chk("trig_count", count, 5'd3);
    chk("trig_rd_valid", rif.rd_valid, 1'b1);
    chk("trig_head", rif.rd_data, 8'hA5);
    chk("trig_timed_out", timed_out, 1'b0);
    rr_force = 1'b1;
    wait_idle("trig_idle", 100);

    // dec_valid held high counts one byte.
    rr_force = 1'b0;
    do_arm(4'd3, 8'h00, 8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h77); exp_q.push_back(8'h55);
    send_byte(8'h01, 1, 1);
    send_byte(8'h77, 5, 2);
    chk("hold_count", count, 5'd2);
    chk("hold_state", state, 2'd2);
    send_byte(8'h55, 1, 1);
    rr_force = 1'b1;
    wait_idle("hold_idle", 100);

    // cap_len=0 -> DEPTH bytes; consumer stalled; arm in READOUT ignored.
    rr_force = 1'b0;
    do_arm(4'd0, 8'h00, 8'h00);
    first = 8'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      b = (i == 0) ? first : 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1, 1);
    end
    chk("full_count", count, 5'(DEPTH));
    for (int i = 0; i < 20; i++) begin
      if (i == 10) arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("stall_valid", rif.rd_valid, 1'b1);
      chk("stall_data", rif.rd_data, first);
    end
    chk("arm_ignored_state", state, 2'd3);
    chk("arm_ignored_count", count, 5'(DEPTH));
    rr_force = 1'b1;
    wait_idle("full_idle", 100);
    chk("full_drained", exp_q.size(), 0);

    // Abort coinciding with the second byte.
    rr_force = 1'b0;
    do_arm(4'd5, 8'h00, 8'h00);
    send_byte(8'h11, 1, 1);
    chk("pre_abort_count", count, 5'd1);
    dec_data = 8'h22; dec_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; dec_valid = 1'b0;
    chk("abort_state", state, 2'd0);
    chk("abort_count", count, 5'd0);
    chk("abort_rd_valid", rif.rd_valid, 1'b0);
    chk("abort_detect", dec_detect_only, 1'b1);
    tick(2);

    // Asynchronous reset in the middle of CAPTURE.
    do_arm(4'd8, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h40), 1, 1);
    chk("pre_rst_count", count, 5'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_count", count, 5'd0);
    chk("mid_rst_rd_valid", rif.rd_valid, 1'b0);
    chk("mid_rst_detect", dec_detect_only, 1'b1);
    tick();
    rst_n = 1'b1;
    tick(2);

`ifdef CAPTURE_TIMEOUT_EN
    begin
      int n = 0;
      rr_force = 1'b0;
      do_arm(4'd5, 8'h00, 8'h00);
      exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
      send_byte(8'h5A, 1, 1);
      send_byte(8'hC3, 1, 1);
      while (state !== 2'd3 && n < 80) begin tick(); n++; end
      chk("tmo_state", state, 2'd3);
      chk("tmo_count", count, 5'd2);
      chk("tmo_flag", timed_out, 1'b1);
      chk("tmo_not_early", n >= 40, 1'b1);
      rr_force = 1'b1;
      wait_idle("tmo_idle", 100);
      chk("tmo_flag_held", timed_out, 1'b1);
      rr_force = 1'b0;
      do_arm(4'd2, 8'h00, 8'h00);
      chk("tmo_flag_cleared", timed_out, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
    end
`else
    chk("tmo_tied_low", timed_out, 1'b0);
`endif

    // Randomized sessions with a randomly stalling consumer.
    rr_rand = 1'b1;
    for (int s = 0; s < 25; s++)
      run_session(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom & $urandom));
    rr_rand = 1'b0;

    tick(5);
    chk("sb_final_drained", exp_q.size(), 0);
    errs   += sb_errs;
    checks += sb_checks;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
